stopwatch_controller: RTL and testbench
=======================================

Name: stopwatch_controller

Overview:
- Sequencer for the 4-digit BCD stopwatch counter (16-bit, 4 nibbles 0-9, wraps 9999->0000, synchronous active-low clear, increments on every clock it is enabled).
- Turns start/stop, lap and clear button levels into a prescaled count-enable pulse, a one-cycle clear strobe and a lap-frozen display value.
- Sits between the debounced button inputs, the BCD counter and the 7-segment display driver.

Parameters:
- CLK_DIV, 500000, clocks per counter increment (tick period); legal range 2 to 2^24.
- DIV_W, 24, prescaler width; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_start_stop  in  1  debounced, synchronous level, active-high
- btn_lap  in  1  debounced, synchronous level, active-high
- btn_clear  in  1  debounced, synchronous level, active-high
- count_bcd  in  16  current value from the BCD counter
- count_en  out  1  one-cycle tick; gates the counter clock enable
- count_clear_n  out  1  active-low clear strobe to the counter
- display_bcd  out  16  value for the display driver
- running  out  1  high in RUN or LAP
- state  out  2  IDLE=0, RUN=1, PAUSED=2, LAP=3

Behaviour:
- Reset (async, active-high):
  - state=IDLE, prescaler=0, lap_reg=0, edge registers=0.
  - count_en=0.
  - count_clear_n=0 while reset is high, so the counter clears. It goes to 1 on the first clock after release.
- Edge detection:
  - Each button has a previous-value register.
  - An event is level=1 and prev=0. A held button gives exactly one event.
  - Events act on the same cycle they are detected.
- Priority when several events coincide in one cycle: clear > start_stop > lap. Only the highest-priority event that is legal in the current state acts; the others are dropped.
- Transitions (illegal events are ignored):
  - IDLE: start_stop -> RUN. clear -> IDLE with a clear pulse.
  - RUN: start_stop -> PAUSED. lap -> LAP, with lap_reg<=count_bcd.
  - LAP: lap -> RUN (display live again). start_stop -> PAUSED (display live).
  - PAUSED: start_stop -> RUN. clear -> IDLE, with a clear pulse, prescaler<=0 and lap_reg<=0.
  - clear is ignored in RUN and LAP.
- Clear pulse: count_clear_n=0 for exactly the one cycle following the accepted clear event (registered output).
- Prescaler:
  - In RUN and LAP it counts 0..CLK_DIV-1 and wraps to 0.
  - count_en is registered. It is 1 for the single cycle after the prescaler reaches CLK_DIV-1, so the tick period is exactly CLK_DIV clocks.
  - In PAUSED the prescaler holds its value, so a partial tick is preserved on resume.
  - In IDLE it is held at 0.
  - count_en is never 1 in IDLE or PAUSED, including the cycle the PAUSED transition is taken: the transition suppresses a terminal-count tick that coincides with it.
- Lap capture:
  - lap_reg samples the count_bcd present on the event cycle.
  - If count_en is high in that same cycle, the pre-increment value is captured.
- display_bcd: lap_reg when state==LAP, otherwise count_bcd (combinational mux, zero latency).
- Counter wrap (9999->0000) is the counter's own behaviour. The controller keeps ticking through it, with no special handling.
- running = (state==RUN) || (state==LAP).

Test Plan (CLK_DIV=4):
- Reset then idle 20 cycles -> count_clear_n low during reset, then 1; count_en never 1; state=0; display_bcd tracks count_bcd.
- start_stop pulse from IDLE -> state=1 next cycle; count_en pulses exactly every 4 cycles. Hold the button 10 cycles -> only one transition.
- In RUN with count_bcd=16'h0123, pulse lap -> state=3, display_bcd=16'h0123 while count_bcd advances to 16'h0125. A second lap -> state=1, display follows count_bcd.
- In RUN, pulse start_stop at prescaler=2 -> PAUSED, no count_en for 50 cycles. Resume -> first count_en 2 cycles later (preserved phase).
- In PAUSED, pulse clear -> count_clear_n=0 for exactly one cycle, state=0, lap_reg=0. Pulse clear in RUN -> no clear pulse, state stays 1.
- start_stop and clear rise in the same cycle in PAUSED -> clear wins (IDLE plus clear pulse). Assert reset mid-RUN between ticks -> state=0 and count_en=0 immediately (async); count_clear_n=0 while reset is high.

Source files
------------

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: turns debounced button levels into a prescaled count
// enable, a one-cycle counter clear strobe and a lap-frozen display value.
module stopwatch_controller #(
    parameter int CLK_DIV = 500000,
    parameter int DIV_W   = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    input  logic [15:0] count_bcd,
    output logic        count_en,
    output logic        count_clear_n,
    output logic [15:0] display_bcd,
    output logic        running,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        LAP    = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    state_t           cur_state;
    state_t           next_state;
    logic [DIV_W-1:0] prescaler;
    logic [DIV_W-1:0] prescaler_next;
    logic [15:0]      lap_reg;
    logic [15:0]      lap_next;
    logic             prev_start_stop;
    logic             prev_lap;
    logic             prev_clear;
    logic             ev_start_stop;
    logic             ev_lap;
    logic             ev_clear;
    logic             clear_accept;
    logic             en_next;
    logic             cur_running;
    logic             next_running;
    logic             terminal;

    assign ev_start_stop = btn_start_stop & ~prev_start_stop;
    assign ev_lap        = btn_lap & ~prev_lap;
    assign ev_clear      = btn_clear & ~prev_clear;

    assign cur_running  = (cur_state == RUN) || (cur_state == LAP);
    assign next_running = (next_state == RUN) || (next_state == LAP);
    assign terminal     = (prescaler == DIV_LAST);

    // Each state checks its legal events in clear > start_stop > lap order.
    always_comb begin
        next_state   = cur_state;
        clear_accept = 1'b0;
        lap_next     = lap_reg;
        case (cur_state)
            IDLE: begin
                if (ev_clear) begin
                    clear_accept = 1'b1;
                    lap_next     = '0;
                end else if (ev_start_stop) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (ev_start_stop) begin
                    next_state = PAUSED;
                end else if (ev_lap) begin
                    next_state = LAP;
                    lap_next   = count_bcd;
                end
            end
            LAP: begin
                if (ev_start_stop) begin
                    next_state = PAUSED;
                end else if (ev_lap) begin
                    next_state = RUN;
                end
            end
            PAUSED: begin
                if (ev_clear) begin
                    next_state   = IDLE;
                    clear_accept = 1'b1;
                    lap_next     = '0;
                end else if (ev_start_stop) begin
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A terminal count coinciding with a pause is swallowed rather than ticked.
    always_comb begin
        prescaler_next = prescaler;
        en_next        = 1'b0;
        if (cur_running) begin
            prescaler_next = terminal ? '0 : prescaler + DIV_W'(1);
            en_next        = terminal && next_running;
        end else if ((cur_state == IDLE) || clear_accept) begin
            prescaler_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state       <= IDLE;
            prescaler       <= '0;
            lap_reg         <= '0;
            prev_start_stop <= 1'b0;
            prev_lap        <= 1'b0;
            prev_clear      <= 1'b0;
            count_en        <= 1'b0;
            count_clear_n   <= 1'b0;
        end else begin
            cur_state       <= next_state;
            prescaler       <= prescaler_next;
            lap_reg         <= lap_next;
            prev_start_stop <= btn_start_stop;
            prev_lap        <= btn_lap;
            prev_clear      <= btn_clear;
            count_en        <= en_next;
            count_clear_n   <= ~clear_accept;
        end
    end

    assign display_bcd = (cur_state == LAP) ? lap_reg : count_bcd;
    assign running     = cur_running;
    assign state       = cur_state;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: a behavioural BCD counter closes the loop and
// a per-cycle reference model feeds expected outputs through a scoreboard queue.
module tb_stopwatch_controller;

    localparam int CLK_DIV = 4;
    localparam int DIV_W   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_start_stop = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clear = 1'b0;
    logic [15:0] count_bcd = 16'h0000;
    logic        count_en;
    logic        count_clear_n;
    logic [15:0] display_bcd;
    logic        running;
    logic [1:0]  state;

    logic        load_req = 1'b0;
    logic [15:0] load_val = 16'h0000;

    typedef struct packed {
        logic [1:0]  st;
        logic        en;
        logic        clrn;
        logic        sel;
        logic [15:0] lapv;
    } exp_t;

    exp_t sb[$];

    logic [1:0]  m_state;
    int          m_pre;
    logic [15:0] m_lap;
    logic        m_en;
    logic        mp_ss;
    logic        mp_lap;
    logic        mp_clr;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    logic [15:0] cap_val;

    stopwatch_controller #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .count_bcd      (count_bcd),
        .count_en       (count_en),
        .count_clear_n  (count_clear_n),
        .display_bcd    (display_bcd),
        .running        (running),
        .state          (state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Stand-in for the real BCD counter so display tracking and lap capture are exercised.
    always @(posedge clk) begin
        if (load_req)
            count_bcd <= load_val;
        else if (!count_clear_n)
            count_bcd <= 16'h0000;
        else if (count_en)
            count_bcd <= bcd_inc(count_bcd);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic resetModel();
        m_state = 2'd0;
        m_pre   = 0;
        m_lap   = 16'h0000;
        m_en    = 1'b0;
        mp_ss   = 1'b0;
        mp_lap  = 1'b0;
        mp_clr  = 1'b0;
    endtask

    task automatic popCompare();
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        checkOutput("state", 32'(state), 32'(e.st));
        checkOutput("count_en", 32'(count_en), 32'(e.en));
        checkOutput("count_clear_n", 32'(count_clear_n), 32'(e.clrn));
        checkOutput("running", 32'(running), 32'((e.st == 2'd1) || (e.st == 2'd3)));
        checkOutput("display", 32'(display_bcd), 32'(e.sel ? e.lapv : count_bcd));
        if (count_en)
            tick_cnt++;
    endtask

    // Drive one cycle of buttons, advance the model, then compare after the edge.
    task automatic applyStimulus(input logic ss, input logic lp, input logic cl);
        logic       e_ss, e_lp, e_cl, clr, tc;
        logic [1:0] n_st;
        int         n_pre;
        logic       n_en;
        logic [15:0] n_lap;
        btn_start_stop = ss;
        btn_lap        = lp;
        btn_clear      = cl;
        e_ss = ss && !mp_ss;
        e_lp = lp && !mp_lap;
        e_cl = cl && !mp_clr;
        n_st  = m_state;
        n_lap = m_lap;
        clr   = 1'b0;
        if (m_state == 2'd0) begin
            if (e_cl) begin clr = 1'b1; n_lap = 16'h0000; end
            else if (e_ss) n_st = 2'd1;
        end else if (m_state == 2'd1) begin
            if (e_ss) n_st = 2'd2;
            else if (e_lp) begin n_st = 2'd3; n_lap = count_bcd; end
        end else if (m_state == 2'd3) begin
            if (e_ss) n_st = 2'd2;
            else if (e_lp) n_st = 2'd1;
        end else begin
            if (e_cl) begin n_st = 2'd0; clr = 1'b1; n_lap = 16'h0000; end
            else if (e_ss) n_st = 2'd1;
        end
        n_en = 1'b0;
        if (m_state == 2'd1 || m_state == 2'd3) begin
            tc    = (m_pre == CLK_DIV - 1);
            n_pre = tc ? 0 : m_pre + 1;
            n_en  = tc && (n_st == 2'd1 || n_st == 2'd3);
        end else if (n_st == 2'd0) begin
            n_pre = 0;
        end else begin
            n_pre = m_pre;
        end
        sb.push_back('{st: n_st, en: n_en, clrn: !clr, sel: (n_st == 2'd3), lapv: n_lap});
        m_state = n_st;
        m_pre   = n_pre;
        m_lap   = n_lap;
        m_en    = n_en;
        mp_ss   = ss;
        mp_lap  = lp;
        mp_clr  = cl;
        @(posedge clk);
        @(negedge clk);
        popCompare();
    endtask

    initial begin
        resetModel();
        repeat (2) @(negedge clk);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_en", 32'(count_en), 32'd0);
        checkOutput("rst_clrn", 32'(count_clear_n), 32'd0);
        reset = 1'b0;

        // Idle with a preloaded counter value so display tracking is visible.
        applyStimulus(0, 0, 0);
        load_val = 16'h4321;
        load_req = 1'b1;
        applyStimulus(0, 0, 0);
        load_req = 1'b0;
        tick_cnt = 0;
        for (int i = 0; i < 18; i++) applyStimulus(0, 0, 0);
        checkOutput("idle_disp", 32'(display_bcd), 32'h4321);
        checkOutput("idle_ticks", 32'(tick_cnt), 32'd0);

        // Start held for ten cycles must only produce one transition.
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0);
        checkOutput("hold_state", 32'(state), 32'd1);
        applyStimulus(0, 0, 0);
        tick_cnt = 0;
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0);
        checkOutput("tick_16", 32'(tick_cnt), 32'd4);

        // Lap freezes 0123 while the counter moves on by two ticks.
        load_val = 16'h0123;
        load_req = 1'b1;
        applyStimulus(0, 0, 0);
        load_req = 1'b0;
        applyStimulus(0, 1, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0);
        checkOutput("lap_state", 32'(state), 32'd3);
        checkOutput("lap_hold", 32'(display_bcd), 32'h0123);
        checkOutput("lap_count", 32'(count_bcd), 32'h0125);
        applyStimulus(0, 1, 0);
        checkOutput("unlap_state", 32'(state), 32'd1);
        applyStimulus(0, 0, 0);

        // Pause at prescaler 2, sit for 50 cycles, resume with phase intact.
        for (int i = 0; i < 8 && m_pre != 2; i++) applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("pause_state", 32'(state), 32'd2);
        tick_cnt = 0;
        for (int i = 0; i < 50; i++) applyStimulus(0, 0, 0);
        checkOutput("pause_ticks", 32'(tick_cnt), 32'd0);
        applyStimulus(1, 0, 0);
        checkOutput("resume_state", 32'(state), 32'd1);
        checkOutput("resume_en0", 32'(count_en), 32'd0);
        applyStimulus(0, 0, 0);
        checkOutput("resume_tick", 32'(count_en), 32'd1);

        // Clear from PAUSED pulses clear_n for a single cycle.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        checkOutput("clr_pulse", 32'(count_clear_n), 32'd0);
        checkOutput("clr_state", 32'(state), 32'd0);
        applyStimulus(0, 0, 0);
        checkOutput("clr_release", 32'(count_clear_n), 32'd1);

        // Clear is ignored while running.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        checkOutput("run_clr_n", 32'(count_clear_n), 32'd1);
        checkOutput("run_clr_state", 32'(state), 32'd1);
        applyStimulus(0, 0, 0);

        // Lap on a tick cycle captures the pre-increment value.
        for (int i = 0; i < 8 && !m_en; i++) applyStimulus(0, 0, 0);
        cap_val = count_bcd;
        applyStimulus(0, 1, 0);
        checkOutput("lap_pre_inc", 32'(display_bcd), 32'(cap_val));
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);

        // Pause on terminal count swallows the tick.
        for (int i = 0; i < 8 && m_pre != CLK_DIV - 1; i++) applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("pause_tc_en", 32'(count_en), 32'd0);
        applyStimulus(0, 0, 0);

        // Simultaneous start_stop and clear in PAUSED: clear wins.
        applyStimulus(1, 0, 1);
        checkOutput("both_state", 32'(state), 32'd0);
        checkOutput("both_clrn", 32'(count_clear_n), 32'd0);
        applyStimulus(0, 0, 0);

        // Asynchronous reset mid-run while count_en is high.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 8 && !m_en; i++) applyStimulus(0, 0, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_state", 32'(state), 32'd0);
        checkOutput("arst_en", 32'(count_en), 32'd0);
        checkOutput("arst_clrn", 32'(count_clear_n), 32'd0);
        @(negedge clk);
        checkOutput("arst_hold_clrn", 32'(count_clear_n), 32'd0);
        reset = 1'b0;
        resetModel();
        sb.delete();
        btn_start_stop = 1'b0;
        btn_lap = 1'b0;
        btn_clear = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
